// File: rtl/fpsub_pipe.sv
// Three-stage FP32 subtractor: out = A + (-B), with truncating alignment and normalization.
// A valid/ready handshake on both sides; a stalled consumer freezes the whole pipe.
module fpsub_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    logic        adv;

    logic        s1_v_q;
    logic [31:0] s1_a_q;
    logic [31:0] s1_b_q;

    logic        s2_v_q;
    logic        s2_sign_q;
    logic [7:0]  s2_exp_q;
    logic [24:0] s2_man_q;
    logic [31:0] s2_a_q;
    logic [31:0] s2_b_q;
    logic        s2_a_zero_q;
    logic        s2_b_zero_q;

    logic        out_valid_q;
    logic [31:0] out_q;

    logic        a_big;
    logic [31:0] op_l;
    logic [31:0] op_s;
    logic [7:0]  exp_diff;
    logic [24:0] man_l;
    logic [24:0] man_s;
    logic [24:0] man_s_sh;
    logic [24:0] s2_man_d;

    logic [4:0]  lz;
    logic        lz_found;
    logic [7:0]  exp_norm;
    logic [22:0] frac_norm;
    logic [31:0] out_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    // Stage 1: capture A and the sign-flipped subtrahend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_q <= 1'b0;
            s1_a_q <= 32'h0;
            s1_b_q <= 32'h0;
        end else if (adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_a_q <= reg_A;
                s1_b_q <= {~reg_B[31], reg_B[30:0]};
            end
        end
    end

    // Stage 2: magnitude compare (A wins ties), align the smaller operand, add or subtract.
    always_comb begin
        a_big    = s1_a_q[30:0] >= s1_b_q[30:0];
        op_l     = a_big ? s1_a_q : s1_b_q;
        op_s     = a_big ? s1_b_q : s1_a_q;
        exp_diff = op_l[30:23] - op_s[30:23];
        man_l    = {2'b01, op_l[22:0]};
        man_s    = {2'b01, op_s[22:0]};
        man_s_sh = (exp_diff >= 8'd25) ? 25'h0 : (man_s >> exp_diff);
        if (op_l[31] == op_s[31]) begin
            s2_man_d = man_l + man_s_sh;
        end else begin
            s2_man_d = man_l - man_s_sh;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_v_q      <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= 8'h0;
            s2_man_q    <= 25'h0;
            s2_a_q      <= 32'h0;
            s2_b_q      <= 32'h0;
            s2_a_zero_q <= 1'b0;
            s2_b_zero_q <= 1'b0;
        end else if (adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_sign_q   <= op_l[31];
                s2_exp_q    <= op_l[30:23];
                s2_man_q    <= s2_man_d;
                s2_a_q      <= s1_a_q;
                s2_b_q      <= s1_b_q;
                s2_a_zero_q <= (s1_a_q == 32'h0);
                // B == 0 shows up here as 8000_0000 after the sign flip.
                s2_b_zero_q <= (s1_b_q == 32'h8000_0000);
            end
        end
    end

    // Stage 3: normalize, then apply the zero-operand overrides.
    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && s2_man_q[i]) begin
                lz       = 5'(23 - i);
                lz_found = 1'b1;
            end
        end

        if (s2_man_q[24]) begin
            exp_norm  = s2_exp_q + 8'd1;
            frac_norm = s2_man_q[23:1];
        end else begin
            exp_norm  = s2_exp_q - {3'b000, lz};
            frac_norm = s2_man_q[22:0] << lz;
        end

        if (s2_a_zero_q) begin
            out_d = s2_b_zero_q ? 32'h0 : s2_b_q;
        end else if (s2_b_zero_q) begin
            out_d = s2_a_q;
        end else if (s2_man_q == 25'h0) begin
            out_d = 32'h0;
        end else begin
            out_d = {s2_sign_q, exp_norm, frac_norm};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= 32'h0;
        end else if (adv) begin
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_q <= out_d;
            end
        end
    end

endmodule

// File: doc/fpsub_pipe.md
Name: fpsub_pipe

Overview:
- Pipelined FP32 subtractor computing out = A - B, implemented as A + (-B).
- This is the subtract direction of the team's single-cycle FP32 adder. It uses the same number-format assumptions, the same truncating arithmetic and the same zero-operand conventions.
- It sits in the FPU datapath behind a valid/ready handshake on both sides, so it can be chained between operand producers and result consumers that may stall.

Parameters:
- none (fixed FP32 format: 1 sign, 8 exponent bits with bias 127, 23 mantissa bits; fixed 3-stage pipeline)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair this cycle
- reg_A  input  32  minuend, FP32
- reg_B  input  32  subtrahend, FP32
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result this cycle
- out  output  32  difference, FP32

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers, valid bits, out and out_valid clear to 0. After reset deasserts, the first accepted pair can be issued on the next rising edge.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Handshake:
  - A pair is accepted on a clock edge where in_valid && in_ready.
  - A result is consumed on an edge where out_valid && out_ready.
  - When adv=0 every stage holds: no data or valid bit changes, and out stays stable.
- Bubbles: stages carry their own valid bits. Invalid stages still shift when adv=1, so bubbles do not block later data.
- Latency: 3 cycles from acceptance to out_valid=1 with no stalls. Throughput is 1 result per cycle while out_ready=1. Order is strictly preserved.
- Stage 1 (capture): register reg_A, and reg_B with its sign bit inverted (B' = -B).
- Stage 2 (align and add):
  - Pick the larger-magnitude operand L: compare exponents first, then mantissas on a tie; A wins on full equality. The other operand is S.
  - Form 25-bit mantissas {2'b01, frac}.
  - Shift S right by (expL - expS), truncating. Shift amounts of 25 or more give 0.
  - If signs are equal, add; otherwise compute L - S (never negative).
  - The result carries sign_L and exp = expL.
- Stage 3 (normalize and select):
  - Carry out (bit 24 = 1): shift the mantissa right 1 and set exp+1.
  - Otherwise, if the sum is nonzero: left-shift by the leading-zero count so that bit 23 = 1, and subtract the count from exp.
  - The fraction is truncated; there is no rounding.
- Result selection, in priority order:
  - A == 32'h0: out = B' (B with its sign flipped), except B == 0 gives 32'h0.
  - B == 32'h0: out = A.
  - Mantissa sum == 0: out = 32'h00000000 (positive zero).
  - Otherwise: out = {sign_L, exp_norm, frac_norm}.
- Only all-zero 32'h0 is treated as a zero operand; 32'h80000000 is processed as a normal number.
- Out of scope: inputs are normal (0 < exp < 255) and results do not overflow or underflow, so there is no NaN, Inf or subnormal handling.
- Reset mid-operation: in-flight results are discarded, with no partial output.
- Simultaneous consume and accept while full: both occur on the same edge, with no loss or duplication.

Test Plan:
- Basic: 40400000 - 3F800000 -> 40000000 (3 - 1 = 2), out_valid exactly 3 cycles after acceptance.
- Sign paths:
  - 3F800000 - BF800000 -> 40000000
  - 3F800000 - 40400000 -> C0000000
  - 3F800000 - 3F800000 -> 00000000
- Normalization and alignment:
  - 3F800000 - 3F400000 -> 3E800000 (left shift of 2)
  - 4E800000 - 3F800000 -> 4E800000 (shift of 30 truncates to 0)
- Zero operands:
  - 00000000 - 3FC00000 -> BFC00000
  - 3FC00000 - 00000000 -> 3FC00000
  - 00000000 - 00000000 -> 00000000
- Backpressure:
  - Stream 5 pairs back-to-back, hold out_ready=0 for 4 cycles mid-stream.
  - in_ready drops, out stays stable, all 5 results arrive in order with none lost or duplicated.
- Reset mid-stream: pulse reset low with 3 pairs in flight -> out_valid=0 and out=0 immediately (asynchronous). No stale result after release; the next pair returns a correct result after 3 cycles.
